// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one single-port synchronous RAM between instruction fetch
// and load/store ports; zero-latency grant, responses routed back one cycle later.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PRIORITY   = 0,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    instr_req_i,
  output logic                    instr_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
  output logic                    instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]   instr_rdata_o,
  input  logic                    data_req_i,
  output logic                    data_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    mem_en_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  typedef enum logic [1:0] {OwnNone, OwnInstr, OwnData} owner_e;

  owner_e     r_resp_owner;
  owner_e     w_resp_owner_d;
  logic       r_resp_we;
  logic       r_last_data;   // 1 when the most recent grant went to the data port
  logic [3:0] r_starve_cnt;
  logic       w_instr_gnt;
  logic       w_data_gnt;
  logic       w_instr_rvalid;
  logic       w_data_rvalid;

  // Grant decision, purely from current-cycle requests and arbitration state
  always_comb begin
    w_instr_gnt = 1'b0;
    w_data_gnt  = 1'b0;
    if (!rst_i) begin
      if (instr_req_i && data_req_i) begin
        if (PRIORITY == 0) begin
          w_instr_gnt = r_last_data;
        end else begin
          w_instr_gnt = (r_starve_cnt == StarveMax);
        end
        w_data_gnt = !w_instr_gnt;
      end else begin
        w_instr_gnt = instr_req_i;
        w_data_gnt  = data_req_i;
      end
    end
  end

  always_comb begin
    w_resp_owner_d = OwnNone;
    if (w_instr_gnt) begin
      w_resp_owner_d = OwnInstr;
    end else if (w_data_gnt) begin
      w_resp_owner_d = OwnData;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_resp_owner <= OwnNone;
      r_resp_we    <= 1'b0;
      r_last_data  <= 1'b1;
      r_starve_cnt <= 4'd0;
    end else begin
      r_resp_owner <= w_resp_owner_d;
      r_resp_we    <= w_data_gnt && data_we_i;
      if (w_instr_gnt) begin
        r_last_data <= 1'b0;
      end else if (w_data_gnt) begin
        r_last_data <= 1'b1;
      end
      if (!instr_req_i || w_instr_gnt) begin
        r_starve_cnt <= 4'd0;
      end else if (r_starve_cnt != StarveMax) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end
  end

  // Pending responses are suppressed while reset is held
  always_comb begin
    w_instr_rvalid = !rst_i && (r_resp_owner == OwnInstr);
    w_data_rvalid  = !rst_i && (r_resp_owner == OwnData);
    instr_gnt_o    = w_instr_gnt;
    data_gnt_o     = w_data_gnt;
    mem_en_o       = w_instr_gnt || w_data_gnt;
    mem_addr_o     = w_data_gnt ? data_addr_i : instr_addr_i;
    mem_we_o       = w_data_gnt && data_we_i;
    mem_be_o       = w_data_gnt ? data_be_i : '0;
    mem_wdata_o    = w_data_gnt ? data_wdata_i : '0;
    instr_rvalid_o = w_instr_rvalid;
    instr_rdata_o  = w_instr_rvalid ? mem_rdata_i : '0;
    data_rvalid_o  = w_data_rvalid;
    data_rdata_o   = (w_data_rvalid && !r_resp_we) ? mem_rdata_i : '0;
  end

endmodule
